// File: rtl/instr_fetch_rtype.sv
// Instruction-fetch stage feeding the R-type datapath: loadable instruction memory,
// byte-addressed PC, one registered instruction per clock, automatic RAW-hazard bubbles.
module instr_fetch_rtype #(
  parameter int MEM_DEPTH      = 64,
  parameter int ADDR_W         = 6,
  parameter int HAZARD_BUBBLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  input  logic              stall,
  output logic [31:0]       instruccion,
  output logic              instr_valid,
  output logic              bubble,
  output logic [31:0]       pc,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, FETCH, BUBBLE, HALT} state_t;

  localparam logic [1:0]  HB        = 2'(HAZARD_BUBBLES);
  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

  state_t            state;
  logic [31:0]       mem [MEM_DEPTH];
  logic [4:0]        last_rd;
  logic [1:0]        nop_cnt;

  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_next;
  logic [31:0]       word;
  logic [5:0]        opcode;
  logic [4:0]        rs, rt, rd;
  logic              hazard;
  logic              more_bubbles;
  logic [1:0]        nop_inc;

  assign idx      = pc[ADDR_W+1:2];
  assign idx_next = idx + ADDR_W'(1);
  assign word     = mem[idx];
  assign opcode   = word[31:26];
  assign rs       = word[25:21];
  assign rt       = word[20:16];
  assign rd       = word[15:11];

  // $0 is never a real destination, so last_rd == 0 disables the tracker.
  assign hazard       = (last_rd != 5'd0) && ((rs == last_rd) || (rt == last_rd)) && (nop_cnt < HB);
  assign more_bubbles = (state == BUBBLE) && (nop_cnt < HB);
  assign nop_inc      = (nop_cnt >= HB) ? nop_cnt : nop_cnt + 2'd1;

  // NOTE: the instruction store has no reset so a program survives rst_n; it lives in
  // its own clocked block, apart from the reset-bearing control registers.
  always_ff @(posedge clk) begin
    if (load_en && (state == IDLE || state == HALT))
      mem[load_addr] <= load_data;
  end

  // NOTE: all sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= 32'd0;
      instruccion <= 32'd0;
      instr_valid <= 1'b0;
      bubble      <= 1'b0;
      done        <= 1'b0;
      last_rd     <= 5'd0;
      nop_cnt     <= HB;
    end else begin
      case (state)
        IDLE: begin
          instruccion <= 32'd0;
          instr_valid <= 1'b0;
          bubble      <= 1'b0;
          done        <= 1'b0;
          if (run) state <= FETCH;
        end

        HALT: begin
          instruccion <= 32'd0;
          instr_valid <= 1'b0;
          bubble      <= 1'b0;
          done        <= 1'b1;
          if (!run) begin
            state <= IDLE;
            pc    <= 32'd0;
            done  <= 1'b0;
          end
        end

        FETCH, BUBBLE: begin
          if (!stall) begin
            if (more_bubbles || (state == FETCH && word != HALT_WORD && hazard)) begin
              instruccion <= 32'd0;
              instr_valid <= 1'b0;
              bubble      <= 1'b1;
              nop_cnt     <= nop_inc;
              state       <= run ? BUBBLE : IDLE;
            end else if (word == HALT_WORD) begin
              instruccion <= 32'd0;
              instr_valid <= 1'b0;
              bubble      <= 1'b0;
              done        <= 1'b1;
              state       <= HALT;
            end else begin
              // Issue path; a BUBBLE that has paid its NOPs lands here with the held word.
              instruccion <= word;
              instr_valid <= 1'b1;
              bubble      <= 1'b0;
              pc          <= 32'({idx_next, 2'b00});
              state       <= run ? FETCH : IDLE;
              if (word == 32'd0) begin
                nop_cnt <= nop_inc;
              end else if (opcode == 6'd0) begin
                last_rd <= rd;
                nop_cnt <= 2'd0;
              end else begin
                last_rd <= 5'd0;
              end
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_rtype.sv
// Directed bench for instr_fetch_rtype: straight issue, RAW bubbles via rs and rt,
// explicit-NOP spacing, stall hold, load protection, wrap-around and async reset.
module tb_instr_fetch_rtype;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic        load_en;
  logic [5:0]  load_addr;
  logic [31:0] load_data;
  logic        stall;
  logic [31:0] instruccion;
  logic        instr_valid;
  logic        bubble;
  logic [31:0] pc;
  logic        done;

  int checks = 0;
  int errors = 0;

  instr_fetch_rtype #(.MEM_DEPTH(64), .ADDR_W(6), .HAZARD_BUBBLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .stall(stall), .instruccion(instruccion),
    .instr_valid(instr_valid), .bubble(bubble), .pc(pc), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic expect_out(input string tag, input logic [31:0] e_instr, input logic e_valid,
                            input logic e_bubble, input logic [31:0] e_pc, input logic e_done);
    check({tag, ".instr"},  instruccion, e_instr);
    check({tag, ".valid"},  32'(instr_valid), 32'(e_valid));
    check({tag, ".bubble"}, 32'(bubble), 32'(e_bubble));
    check({tag, ".pc"},     pc, e_pc);
    check({tag, ".done"},   32'(done), 32'(e_done));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [5:0] addr, input logic [31:0] data);
    load_en   = 1'b1;
    load_addr = addr;
    load_data = data;
    step();
    load_en   = 1'b0;
  endtask

  task automatic pulse_reset();
    run   = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0; stall = 1'b0;
    #2;
    expect_out("reset", 32'h0, 1'b0, 1'b0, 32'd0, 1'b0);
    step();
    rst_n = 1'b1;
    step(); step();
    expect_out("idle_run0", 32'h0, 1'b0, 1'b0, 32'd0, 1'b0);

    // Straight issue: rs=5/rt=15 of the second word do not hit rd=20 of the first.
    load(6'd0, 32'h01E9A022);
    load(6'd1, 32'h00AF7820);
    load(6'd2, 32'hFFFFFFFF);
    run = 1'b1;
    step();
    expect_out("s.fetch_entry", 32'h0, 1'b0, 1'b0, 32'd0, 1'b0);
    step();
    expect_out("s.w0", 32'h01E9A022, 1'b1, 1'b0, 32'd4, 1'b0);
    step();
    expect_out("s.w1", 32'h00AF7820, 1'b1, 1'b0, 32'd8, 1'b0);
    step();
    expect_out("s.halt", 32'h0, 1'b0, 1'b0, 32'd8, 1'b1);
    step();
    expect_out("s.halt_hold", 32'h0, 1'b0, 1'b0, 32'd8, 1'b1);
    run = 1'b0;
    step();
    expect_out("s.back_idle", 32'h0, 1'b0, 1'b0, 32'd0, 1'b0);

    // RAW via rs, then a 3-cycle stall while the bubble is on the output.
    pulse_reset();
    load(6'd1, 32'h0289A022);
    run = 1'b1;
    step();
    step();
    expect_out("h.w0", 32'h01E9A022, 1'b1, 1'b0, 32'd4, 1'b0);
    step();
    expect_out("h.bubble", 32'h0, 1'b0, 1'b1, 32'd4, 1'b0);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out($sformatf("h.stall%0d", i), 32'h0, 1'b0, 1'b1, 32'd4, 1'b0);
    end
    stall = 1'b0;
    step();
    expect_out("h.w1", 32'h0289A022, 1'b1, 1'b0, 32'd8, 1'b0);
    step();
    expect_out("h.halt", 32'h0, 1'b0, 1'b0, 32'd8, 1'b1);

    // RAW via rt.
    pulse_reset();
    load(6'd0, 32'h00AF7820);
    load(6'd1, 32'h012F7820);
    load(6'd2, 32'hFFFFFFFF);
    run = 1'b1;
    step();
    step();
    expect_out("rt.w0", 32'h00AF7820, 1'b1, 1'b0, 32'd4, 1'b0);
    step();
    expect_out("rt.bubble", 32'h0, 1'b0, 1'b1, 32'd4, 1'b0);
    step();
    expect_out("rt.w1", 32'h012F7820, 1'b1, 1'b0, 32'd8, 1'b0);
    step();
    expect_out("rt.halt", 32'h0, 1'b0, 1'b0, 32'd8, 1'b1);

    // Same pair separated by an explicit NOP: no bubble.
    pulse_reset();
    load(6'd1, 32'h00000000);
    load(6'd2, 32'h012F7820);
    load(6'd3, 32'hFFFFFFFF);
    run = 1'b1;
    step();
    step();
    expect_out("nop.w0", 32'h00AF7820, 1'b1, 1'b0, 32'd4, 1'b0);
    step();
    expect_out("nop.nop", 32'h00000000, 1'b1, 1'b0, 32'd8, 1'b0);
    step();
    expect_out("nop.w2", 32'h012F7820, 1'b1, 1'b0, 32'd12, 1'b0);
    step();
    expect_out("nop.halt", 32'h0, 1'b0, 1'b0, 32'd12, 1'b1);

    // Full memory of I-type words, no halt: wrap, load protection, pause/resume.
    pulse_reset();
    for (int i = 0; i < 64; i++) load(6'(i), 32'h20000000 + 32'(i));
    run = 1'b1;
    step();
    load_en = 1'b1; load_addr = 6'd0; load_data = 32'hDEADBEEF;
    step();
    expect_out("w.i0", 32'h20000000, 1'b1, 1'b0, 32'd4, 1'b0);
    step();
    load_en = 1'b0;
    check("w.i1", instruccion, 32'h20000001);
    for (int i = 2; i < 64; i++) step();
    expect_out("w.i63", 32'h2000003F, 1'b1, 1'b0, 32'd0, 1'b0);
    step();
    expect_out("w.replay0", 32'h20000000, 1'b1, 1'b0, 32'd4, 1'b0);
    run = 1'b0;
    step();
    expect_out("w.last_issue", 32'h20000001, 1'b1, 1'b0, 32'd8, 1'b0);
    step();
    expect_out("w.idle", 32'h0, 1'b0, 1'b0, 32'd8, 1'b0);
    run = 1'b1;
    step();
    step();
    expect_out("w.resume", 32'h20000002, 1'b1, 1'b0, 32'd12, 1'b0);

    // Async reset mid-program takes effect without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    expect_out("async_rst", 32'h0, 1'b0, 1'b0, 32'd0, 1'b0);
    run = 1'b0;
    step();
    rst_n = 1'b1;
    run = 1'b1;
    step();
    step();
    expect_out("rst.replay0", 32'h20000000, 1'b1, 1'b0, 32'd4, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
